// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse/PWM measurement block.
// State encoding is fixed so software and benches can decode it.
package pulse_meter_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pm_state_t;

endpackage

// File: rtl/pulse_meter_bit_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Chain clears to 0 on reset so a held-low input shows no edge.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and period of an asynchronous waveform in clk
// cycles, reporting once per completed rising-to-rising period.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_width,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic             r_s_d;
    pm_state_t        r_state;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_per;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(sig_in),
        .o_q(w_s)
    );

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_d      <= 1'b0;
            r_state    <= SEEK;
            r_hi       <= '0;
            r_per      <= '0;
            high_width <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_s_d      <= w_s;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (!en) begin
                r_state <= SEEK;
                r_hi    <= '0;
                r_per   <= '0;
            end else begin
                case (r_state)
                    SEEK: begin
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_hi    <= ONE;
                            r_per   <= ONE;
                        end
                    end
                    HIGH: begin
                        // No rise is possible while high, so max means overflow
                        if (r_per == MAX) begin
                            timeout <= 1'b1;
                            r_hi    <= '0;
                            r_per   <= '0;
                            r_state <= SEEK;
                        end else if (w_fall) begin
                            r_per   <= r_per + ONE;
                            r_state <= LOW;
                        end else begin
                            r_per <= r_per + ONE;
                            r_hi  <= r_hi + ONE;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            high_width <= r_hi;
                            period     <= r_per;
                            meas_valid <= 1'b1;
                            r_hi       <= ONE;
                            r_per      <= ONE;
                            r_state    <= HIGH;
                        end else if (r_per == MAX) begin
                            timeout <= 1'b1;
                            r_hi    <= '0;
                            r_per   <= '0;
                            r_state <= SEEK;
                        end else begin
                            r_per <= r_per + ONE;
                        end
                    end
                    default: begin
                        r_state <= SEEK;
                        r_hi    <= '0;
                        r_per   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench: a 16-bit and an 8-bit meter share all inputs.
// Expected widths/periods are hand-derived from the driven waveform.
module tb_pulse_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic [15:0] hw16;
    logic [15:0] per16;
    logic        mv16;
    logic        to16;
    logic [7:0]  hw8;
    logic [7:0]  per8;
    logic        mv8;
    logic        to8;

    int checks = 0;
    int errors = 0;

    logic [31:0] q16[$];
    int n_mv8   = 0;
    int n_to8   = 0;
    int n_to16  = 0;
    int overlap = 0;
    int wide    = 0;
    logic mv16_d = 1'b0;
    logic mv8_d  = 1'b0;
    logic to8_d  = 1'b0;

    pulse_meter #(
        .CNT_W(16),
        .SYNC_STAGES(2)
    ) u16 (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sig_in(sig_in),
        .high_width(hw16),
        .period(per16),
        .meas_valid(mv16),
        .timeout(to16)
    );

    pulse_meter #(
        .CNT_W(8),
        .SYNC_STAGES(2)
    ) u8 (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sig_in(sig_in),
        .high_width(hw8),
        .period(per8),
        .meas_valid(mv8),
        .timeout(to8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mv16) q16.push_back({hw16, per16});
        if (mv8) n_mv8++;
        if (to8) n_to8++;
        if (to16) n_to16++;
        if ((mv16 && to16) || (mv8 && to8)) overlap++;
        if ((mv16 && mv16_d) || (mv8 && mv8_d) || (to8 && to8_d)) wide++;
        mv16_d = mv16;
        mv8_d  = mv8;
        to8_d  = to8;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_q(input string tag, input int base, input int idx,
                         input logic [15:0] h, input logic [15:0] p);
        if (q16.size() > base + idx) begin
            chk(tag, q16[base + idx], {h, p});
        end else begin
            chk({tag, "_missing"}, 32'(q16.size()), 32'(base + idx + 1));
        end
    endtask

    int base;
    int b_mv8;
    int b_to8;

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        sig_in = 1'b0;
        #1;
        chk("rst_hw16", 32'(hw16), 32'd0);
        chk("rst_per16", 32'(per16), 32'd0);
        chk("rst_mv16", 32'(mv16), 32'd0);
        chk("rst_to16", 32'(to16), 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // 1: 400/400 square wave, four rises -> three reports
        base = q16.size();
        drive(0, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1, 400);
            drive(0, 400);
        end
        drive(1, 5);
        chk("t1_count", 32'(q16.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) chk_q("t1_val", base, i, 16'd400, 16'd800);

        // 2: 1/3 then 1/1 patterns, no missed periods
        do_reset();
        base = q16.size();
        drive(0, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1);
            drive(0, 3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1);
            drive(0, 1);
        end
        drive(1, 1);
        drive(0, 5);
        chk("t2_count", 32'(q16.size() - base), 32'd6);
        for (int i = 0; i < 3; i++) chk_q("t2_a", base, i, 16'd1, 16'd4);
        for (int i = 3; i < 6; i++) chk_q("t2_b", base, i, 16'd1, 16'd2);

        // 3: 8-bit meter, period 255 valid, period 256 times out
        do_reset();
        b_mv8 = n_mv8;
        b_to8 = n_to8;
        drive(0, 5);
        drive(1, 100);
        drive(0, 155);
        drive(1, 100);
        drive(0, 156);
        drive(1, 5);
        chk("t3_mv8", 32'(n_mv8 - b_mv8), 32'd1);
        chk("t3_to8", 32'(n_to8 - b_to8), 32'd1);
        chk("t3_hw8", 32'(hw8), 32'd100);
        chk("t3_per8", 32'(per8), 32'd255);
        drive(0, 5);

        // 4: held high -> one timeout 255 cycles after the rise
        do_reset();
        b_mv8 = n_mv8;
        b_to8 = n_to8;
        drive(0, 5);
        drive(1, 250);
        chk("t4_early_to", 32'(n_to8 - b_to8), 32'd0);
        drive(1, 50);
        chk("t4_to", 32'(n_to8 - b_to8), 32'd1);
        drive(0, 10);
        for (int i = 0; i < 2; i++) begin
            drive(1, 2);
            drive(0, 3);
        end
        drive(1, 2);
        drive(0, 5);
        chk("t4_mv8", 32'(n_mv8 - b_mv8), 32'd2);
        chk("t4_hw8", 32'(hw8), 32'd2);
        chk("t4_per8", 32'(per8), 32'd5);
        chk("t4_to_once", 32'(n_to8 - b_to8), 32'd1);

        // 5: en dropped mid-LOW; the stretched period must not be reported
        do_reset();
        base = q16.size();
        drive(0, 5);
        drive(1, 3);
        drive(0, 5);
        drive(1, 3);
        drive(0, 4);
        en = 1'b0;
        drive(0, 10);
        chk("t5_hold_count", 32'(q16.size() - base), 32'd1);
        chk("t5_hold_hw", 32'(hw16), 32'd3);
        chk("t5_hold_per", 32'(per16), 32'd8);
        en = 1'b1;
        drive(0, 3);
        drive(1, 3);
        drive(0, 5);
        chk("t5_one_rise", 32'(q16.size() - base), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 3);
            drive(0, 5);
        end
        chk("t5_count", 32'(q16.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) chk_q("t5_val", base, i, 16'd3, 16'd8);

        // 6: reset mid-HIGH clears outputs without a clock edge
        do_reset();
        drive(0, 5);
        drive(1, 4);
        drive(0, 6);
        drive(1, 4);
        chk("t6_pre_hw", 32'(hw16), 32'd4);
        chk("t6_pre_per", 32'(per16), 32'd10);
        rst = 1'b1;
        #1;
        chk("t6_async_hw", 32'(hw16), 32'd0);
        chk("t6_async_per", 32'(per16), 32'd0);
        drive(1, 2);
        drive(0, 5);
        rst = 1'b0;
        base = q16.size();
        drive(0, 3);
        drive(1, 4);
        drive(0, 6);
        chk("t6_one_rise", 32'(q16.size() - base), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 4);
            drive(0, 6);
        end
        chk("t6_count", 32'(q16.size() - base), 32'd2);
        for (int i = 0; i < 2; i++) chk_q("t6_val", base, i, 16'd4, 16'd10);

        chk("to16_none", 32'(n_to16), 32'd0);
        chk("pulse_overlap", 32'(overlap), 32'd0);
        chk("pulse_wide", 32'(wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
